// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the reset sequencer: FSM encoding, board defaults
// and width helpers used to size the stage index and delay counters.
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } seq_state_t;

  // Defaults for the 12 MHz board clock (TIMEOUT is roughly 100 us).
  localparam int DEFAULT_STAGE_DELAY = 12;
  localparam int DEFAULT_TIMEOUT     = 1200;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int delay, input int timeout);
    return $clog2(((delay > timeout) ? delay : timeout) + 1);
  endfunction

endpackage

// File: rtl/reset_sync.sv
// Async-assert / sync-deassert reset synchroniser. A 1 is shifted in after
// i_rst_n rises; the output goes high SYNC_STAGES edges later.
module reset_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic i_rst_n,
  output logic o_rst_n_sync
);

  logic [SYNC_STAGES-1:0] chain_q;
  logic [SYNC_STAGES-1:0] chain_d;

  always_comb begin
    chain_d = {chain_q[SYNC_STAGES-2:0], 1'b1};
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign o_rst_n_sync = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Releases NUM_STAGES downstream reset domains one after another, waiting for
// each domain's ready (or a timeout) before starting the next stage delay.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter  int NUM_STAGES  = 4,
  parameter  int SYNC_STAGES = 2,
  parameter  int STAGE_DELAY = DEFAULT_STAGE_DELAY,
  parameter  int TIMEOUT     = DEFAULT_TIMEOUT,
  localparam int IDX_W       = idx_width(NUM_STAGES),
  localparam int CNT_W       = cnt_width(STAGE_DELAY, TIMEOUT)
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic                  i_soft_rst,
  input  logic [NUM_STAGES-1:0] i_stage_ready,
  output logic [NUM_STAGES-1:0] o_rst,
  output logic                  o_done,
  output logic                  o_timeout,
  output logic [IDX_W-1:0]      o_fault_stage
);

  logic                  rel_sync;
  seq_state_t            state_q, state_d;
  logic [IDX_W-1:0]      stage_q, stage_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_STAGES-1:0] rst_q, rst_d;
  logic                  done_q, done_d;
  logic                  timeout_q, timeout_d;
  logic [IDX_W-1:0]      fault_q, fault_d;
  logic                  ready_sel;

  reset_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_reset_sync (
    .clk          (clk),
    .i_rst_n      (i_rst_n),
    .o_rst_n_sync (rel_sync)
  );

  // Only the ready bit of the stage currently being awaited matters.
  always_comb begin
    ready_sel = 1'b0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (stage_q == IDX_W'(i)) ready_sel = i_stage_ready[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    stage_d   = stage_q;
    cnt_d     = cnt_q;
    rst_d     = rst_q;
    done_d    = done_q;
    timeout_d = timeout_q;
    fault_d   = fault_q;
    if (i_soft_rst) begin
      state_d   = S_HOLD;
      stage_d   = '0;
      cnt_d     = '0;
      rst_d     = '1;
      done_d    = 1'b0;
      timeout_d = 1'b0;
      fault_d   = '0;
    end else if (rel_sync) begin
      case (state_q)
        S_HOLD: begin
          if (cnt_q == CNT_W'(STAGE_DELAY - 1)) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
              if (stage_q == IDX_W'(i)) rst_d[i] = 1'b0;
            end
            cnt_d   = '0;
            state_d = S_WAIT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_WAIT: begin
          // A late ready on the timeout edge still counts as a clean handshake.
          if (ready_sel || (cnt_q == CNT_W'(TIMEOUT - 1))) begin
            if (!ready_sel) begin
              timeout_d = 1'b1;
              fault_d   = stage_q;
            end
            cnt_d = '0;
            if (stage_q == IDX_W'(NUM_STAGES - 1)) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              stage_d = stage_q + 1'b1;
              state_d = S_HOLD;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          state_d = S_DONE;
        end
        default: begin
          state_d = S_HOLD;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_HOLD;
      stage_q   <= '0;
      cnt_q     <= '0;
      rst_q     <= '1;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      fault_q   <= '0;
    end else begin
      state_q   <= state_d;
      stage_q   <= stage_d;
      cnt_q     <= cnt_d;
      rst_q     <= rst_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      fault_q   <= fault_d;
    end
  end

  assign o_rst         = rst_q;
  assign o_done        = done_q;
  assign o_timeout     = timeout_q;
  assign o_fault_stage = fault_q;

endmodule
